dominos_input_cond: RTL and testbench

//  Conditions the merged player controls (USB or DB9/DB15, already muxed) before the dominos core.

---
 rtl/dominos_input_pkg.sv | 52 +++++
 rtl/dominos_input_cond_if.sv | 30 +++
 rtl/dominos_input_cond_debounce.sv | 47 ++++
 rtl/dominos_input_cond.sv | 188 ++++++++++++++++++
 tb/tb_dominos_input_cond.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dominos_input_pkg.sv
// Shared definitions for the dominos player-input conditioner.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dominos_input_pkg;

    // Bit positions inside one player's 7-bit control word.
    localparam int JB_R      = 0;
    localparam int JB_L      = 1;
    localparam int JB_D      = 2;
    localparam int JB_U      = 3;
    localparam int JB_COIN   = 4;
    localparam int JB_S1     = 5;
    localparam int JB_S2     = 6;
    localparam int JB_W      = 7;
    localparam int N_PLAYERS = 2;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_U,
        DIR_D,
        DIR_L,
        DIR_R
    } dir_t;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_PULSE,
        CS_GAP,
        CS_WAIT_REL
    } coin_st_t;

    // Highest-priority direction set in v (U > D > L > R); v uses the JB_* layout.
    function automatic dir_t pick_dir(input logic [3:0] v);
        if (v[JB_U])      return DIR_U;
        else if (v[JB_D]) return DIR_D;
        else if (v[JB_L]) return DIR_L;
        else if (v[JB_R]) return DIR_R;
        else              return DIR_NONE;
    endfunction

    // True when direction d is currently held in v.
    function automatic logic dir_held(input dir_t d, input logic [3:0] v);
        case (d)
            DIR_U:   return v[JB_U];
            DIR_D:   return v[JB_D];
            DIR_L:   return v[JB_L];
            DIR_R:   return v[JB_R];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dominos_input_cond_if.sv
// Bundles raw player controls and the conditioned active-low core pins.
// Latency: n/a (wiring only).
// Backpressure: none; level signals, no handshake.
//   master: drives joy0_i/joy1_i, observes outputs (bench / board glue)
//   slave : the conditioner itself
interface dominos_input_cond_if;
    import dominos_input_pkg::*;

    logic [JB_W-1:0]      joy0_i;
    logic [JB_W-1:0]      joy1_i;
    logic [N_PLAYERS-1:0] up_n;
    logic [N_PLAYERS-1:0] down_n;
    logic [N_PLAYERS-1:0] left_n;
    logic [N_PLAYERS-1:0] right_n;
    logic [N_PLAYERS-1:0] coin_n;
    logic                 start1_n;
    logic                 start2_n;
    logic                 tick_1ms;

    modport master (
        output joy0_i, joy1_i,
        input  up_n, down_n, left_n, right_n, coin_n, start1_n, start2_n, tick_1ms
    );

    modport slave (
        input  joy0_i, joy1_i,
        output up_n, down_n, left_n, right_n, coin_n, start1_n, start2_n, tick_1ms
    );

endinterface

// File: rtl/dominos_input_cond_debounce.sv
// One-bit 2-FF synchroniser plus tick-based debouncer.
// Latency: 2 cycles sync + DEBOUNCE_MS ticks (+ up to one tick of phase) to o_deb.
// Backpressure: none; free-running level filter.
//   ports: clk_sys, reset (async, active-high), i_raw (async input),
//          i_tick (shared 1 ms strobe), o_deb (accepted level)
module input_debounce #(
    parameter int DEBOUNCE_MS = 5
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_deb
);

    logic       r_meta;
    logic       r_raw_s;
    logic       r_deb;
    logic [3:0] r_cnt;

    // The counter only survives while raw_s disagrees with deb, so any
    // return to the accepted level throws away partial progress.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_raw_s <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_meta  <= i_raw;
            r_raw_s <= r_meta;
            if (r_raw_s == r_deb) begin
                r_cnt <= 4'd0;
            end else if (i_tick) begin
                if (r_cnt + 4'd1 == 4'(DEBOUNCE_MS)) begin
                    r_deb <= r_raw_s;
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/dominos_input_cond.sv
// Conditions merged player controls: sync/debounce, 4-way stick resolve, coin pulse, start merge.
// Latency: raw edge -> output = 2 sync cycles + DEBOUNCE_MS ticks (+ tick phase) + 1 cycle.
// Backpressure: none; outputs are registered active-low levels for the core.
//   ports: clk_sys, reset (async, active-high), io (dominos_input_cond_if.slave)
module dominos_input_cond
    import dominos_input_pkg::*;
#(
    parameter int CLK_FREQ      = 12000000,
    parameter int DEBOUNCE_MS   = 5,
    parameter int COIN_PULSE_MS = 50,
    parameter int COIN_GAP_MS   = 100
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    dominos_input_cond_if.slave  io
);

    localparam int DIV = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NB  = N_PLAYERS * JB_W;

    // ---------------- 1 ms prescaler ----------------
    logic [PW-1:0] r_pre;
    logic          w_tick;

    assign w_tick = (r_pre == PW'(DIV - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    assign io.tick_1ms = w_tick;

    // ---------------- sync + debounce, all 14 bits ----------------
    logic [NB-1:0] w_raw;
    logic [NB-1:0] w_deb;

    assign w_raw = {io.joy1_i, io.joy0_i};

    for (genvar g = 0; g < NB; g++) begin : g_deb
        input_debounce #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_deb (
            .clk_sys (clk_sys),
            .reset   (reset),
            .i_raw   (w_raw[g]),
            .i_tick  (w_tick),
            .o_deb   (w_deb[g])
        );
    end

    // ---------------- per-player resolver and coin FSM ----------------
    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        logic [3:0] w_dirs;
        logic [3:0] w_rise;
        logic       w_coin;
        dir_t       w_sel_nxt;

        dir_t       r_sel;
        logic [3:0] r_dir_prev;
        logic       r_up_n;
        logic       r_down_n;
        logic       r_left_n;
        logic       r_right_n;

        coin_st_t   r_cst;
        logic [7:0] r_tcnt;
        logic       r_coin_prev;
        logic       r_coin_n;

        assign w_dirs = w_deb[p*JB_W +: 4];
        assign w_coin = w_deb[p*JB_W + JB_COIN];
        assign w_rise = w_dirs & ~r_dir_prev;

        // A fresh press always takes over; otherwise only losing the
        // selected direction forces a re-pick among what is still held.
        always_comb begin
            w_sel_nxt = r_sel;
            if (|w_rise) begin
                w_sel_nxt = pick_dir(w_rise);
            end else if (r_sel != DIR_NONE && !dir_held(r_sel, w_dirs)) begin
                w_sel_nxt = pick_dir(w_dirs);
            end
        end

        // Outputs are decoded from the next selection so they land in
        // the same cycle as r_sel, one cycle after deb moves.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_sel      <= DIR_NONE;
                r_dir_prev <= 4'd0;
                r_up_n     <= 1'b1;
                r_down_n   <= 1'b1;
                r_left_n   <= 1'b1;
                r_right_n  <= 1'b1;
            end else begin
                r_sel      <= w_sel_nxt;
                r_dir_prev <= w_dirs;
                r_up_n     <= (w_sel_nxt != DIR_U);
                r_down_n   <= (w_sel_nxt != DIR_D);
                r_left_n   <= (w_sel_nxt != DIR_L);
                r_right_n  <= (w_sel_nxt != DIR_R);
            end
        end

        // Coin edge history updates in every state, so a press made during
        // PULSE/GAP is consumed there and never replays on return to IDLE.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_cst       <= CS_IDLE;
                r_tcnt      <= 8'd0;
                r_coin_prev <= 1'b0;
                r_coin_n    <= 1'b1;
            end else begin
                r_coin_prev <= w_coin;
                case (r_cst)
                    CS_IDLE: begin
                        if (w_coin && !r_coin_prev) begin
                            r_cst    <= CS_PULSE;
                            r_coin_n <= 1'b0;
                            r_tcnt   <= 8'd0;
                        end
                    end
                    CS_PULSE: begin
                        if (w_tick) begin
                            if (r_tcnt + 8'd1 == 8'(COIN_PULSE_MS)) begin
                                r_cst    <= CS_GAP;
                                r_coin_n <= 1'b1;
                                r_tcnt   <= 8'd0;
                            end else begin
                                r_tcnt <= r_tcnt + 8'd1;
                            end
                        end
                    end
                    CS_GAP: begin
                        if (w_tick) begin
                            if (r_tcnt + 8'd1 == 8'(COIN_GAP_MS)) begin
                                r_cst  <= CS_WAIT_REL;
                                r_tcnt <= 8'd0;
                            end else begin
                                r_tcnt <= r_tcnt + 8'd1;
                            end
                        end
                    end
                    CS_WAIT_REL: begin
                        if (!w_coin) begin
                            r_cst <= CS_IDLE;
                        end
                    end
                    default: begin
                        r_cst    <= CS_IDLE;
                        r_coin_n <= 1'b1;
                    end
                endcase
            end
        end

        assign io.up_n[p]    = r_up_n;
        assign io.down_n[p]  = r_down_n;
        assign io.left_n[p]  = r_left_n;
        assign io.right_n[p] = r_right_n;
        assign io.coin_n[p]  = r_coin_n;
    end

    // ---------------- start buttons, shared by both players ----------------
    logic r_start1_n;
    logic r_start2_n;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_start1_n <= 1'b1;
            r_start2_n <= 1'b1;
        end else begin
            r_start1_n <= ~(w_deb[JB_S1] | w_deb[JB_W + JB_S1]);
            r_start2_n <= ~(w_deb[JB_S2] | w_deb[JB_W + JB_S2]);
        end
    end

    assign io.start1_n = r_start1_n;
    assign io.start2_n = r_start2_n;

endmodule

// File: tb/tb_dominos_input_cond.sv
// Directed self-checking bench for dominos_input_cond.
// Latency: n/a.
// Backpressure: n/a.
module tb_dominos_input_cond;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    dominos_input_cond_if io ();

    dominos_input_cond #(
        .CLK_FREQ      (4000),
        .DEBOUNCE_MS   (2),
        .COIN_PULSE_MS (3),
        .COIN_GAP_MS   (2)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io      (io.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] outs_vec();
        return {io.up_n, io.down_n, io.left_n, io.right_n, io.coin_n, io.start1_n, io.start2_n};
    endfunction

    // {up_n, down_n, left_n, right_n}, two bits each, [P2,P1]
    function automatic logic [7:0] dirs_vec();
        return {io.up_n, io.down_n, io.left_n, io.right_n};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Leaves the caller one cycle after a tick cycle, i.e. a known tick phase.
    task automatic align_tick();
        int k;
        k = 0;
        while (k < 20) begin
            @(negedge clk_sys);
            if (io.tick_1ms) break;
            k++;
        end
        check_eq("tick_seen", 32'(k < 20), 32'd1);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic watch_coin(input int p, input int ncyc,
                              output int pulses, output int width, output int ticks);
        logic prev;
        logic cur;
        pulses = 0;
        width  = 0;
        ticks  = 0;
        prev   = io.coin_n[p];
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk_sys);
            #1;
            cur = io.coin_n[p];
            if (!cur) begin
                width++;
                if (io.tick_1ms) ticks++;
            end
            if (prev && !cur) pulses++;
            prev = cur;
        end
    endtask

    initial begin
        int lows;
        int lat;
        int pulses;
        int width;
        int ticks;
        logic found;

        io.joy0_i = '0;
        io.joy1_i = '0;

        // ---- 1. reset with inputs toggling ----
        for (int i = 0; i < 10; i++) begin
            io.joy0_i = 7'(i * 13 + 5);
            io.joy1_i = 7'(~(i * 29));
            @(posedge clk_sys);
            #1;
        end
        check_eq("rst_outs", 32'(outs_vec()), 32'hFFF);
        check_eq("rst_tick", 32'(io.tick_1ms), 32'd0);
        io.joy0_i = '0;
        io.joy1_i = '0;
        reset = 1'b0;
        cyc(3);
        check_eq("post_rst_outs", 32'(outs_vec()), 32'hFFF);

        // ---- 2. glitch rejection and debounce latency ----
        align_tick();
        lows = 0;
        io.joy0_i[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (!io.up_n[0]) lows++;
        end
        io.joy0_i[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!io.up_n[0]) lows++;
        end
        check_eq("glitch_no_up", 32'(lows), 32'd0);

        io.joy0_i[3] = 1'b1;
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            cyc(1);
            lat++;
            if (!io.up_n[0]) found = 1'b1;
        end
        check_eq("up_seen", 32'(found), 32'd1);
        check_eq("up_latency_ok", 32'(lat >= 7 && lat <= 15), 32'd1);
        cyc(10);
        check_eq("up_hold", 32'(dirs_vec()), 32'b10_11_11_11);

        // ---- 3. 4-way resolution ----
        io.joy0_i[0] = 1'b1;               // add R while U held
        cyc(20);
        check_eq("u_then_r", 32'(dirs_vec()), 32'b11_11_11_10);
        io.joy0_i[0] = 1'b0;               // release R, U still held
        cyc(20);
        check_eq("r_release", 32'(dirs_vec()), 32'b10_11_11_11);
        io.joy0_i = '0;
        cyc(20);
        check_eq("all_release", 32'(dirs_vec()), 32'hFF);
        io.joy0_i = 7'b0001010;            // U and L together
        cyc(20);
        check_eq("u_l_same", 32'(dirs_vec()), 32'b10_11_11_11);
        io.joy0_i = 7'b0000010;            // drop U, L still held
        cyc(20);
        check_eq("fall_to_l", 32'(dirs_vec()), 32'b11_11_10_11);
        io.joy0_i = '0;
        io.joy1_i = 7'b0000100;            // P2 down, independent of P1
        cyc(20);
        check_eq("p2_down", 32'(dirs_vec()), 32'b11_01_11_11);
        io.joy1_i = '0;
        cyc(20);

        // ---- 6. start merge ----
        io.joy1_i[5] = 1'b1;
        cyc(20);
        check_eq("start1_p2", 32'({io.start1_n, io.start2_n}), 32'b01);
        io.joy1_i[5] = 1'b0;
        io.joy0_i[6] = 1'b1;
        io.joy1_i[6] = 1'b1;
        cyc(20);
        check_eq("start2_both", 32'({io.start1_n, io.start2_n}), 32'b10);
        io.joy0_i[6] = 1'b0;
        cyc(20);
        check_eq("start2_one", 32'({io.start1_n, io.start2_n}), 32'b10);
        io.joy1_i[6] = 1'b0;
        cyc(20);
        check_eq("start_none", 32'({io.start1_n, io.start2_n}), 32'b11);

        // ---- 4. coin pulse, held coin ----
        io.joy1_i[4] = 1'b1;
        watch_coin(1, 200, pulses, width, ticks);
        check_eq("coin_hold_pulses", 32'(pulses), 32'd1);
        check_eq("coin_hold_ticks", 32'(ticks), 32'd3);
        check_eq("coin_hold_width", 32'(width >= 9 && width <= 12), 32'd1);
        check_eq("coin_p1_idle", 32'(io.coin_n[0]), 32'd1);
        io.joy1_i[4] = 1'b0;
        cyc(20);
        io.joy1_i[4] = 1'b1;
        watch_coin(1, 60, pulses, width, ticks);
        check_eq("coin_again_pulses", 32'(pulses), 32'd1);
        check_eq("coin_again_ticks", 32'(ticks), 32'd3);
        io.joy1_i[4] = 1'b0;
        cyc(30);

        // ---- 5a. press-release-press inside PULSE/GAP ----
        align_tick();
        fork
            begin
                io.joy1_i[4] = 1'b1;
                cyc(9);
                io.joy1_i[4] = 1'b0;
                cyc(7);
                io.joy1_i[4] = 1'b1;
                cyc(30);
                io.joy1_i[4] = 1'b0;
            end
            begin
                watch_coin(1, 90, pulses, width, ticks);
            end
        join
        check_eq("lockout_pulses", 32'(pulses), 32'd1);
        check_eq("lockout_ticks", 32'(ticks), 32'd3);

        // ---- 5b. reset in the middle of a pulse ----
        io.joy0_i[4] = 1'b1;
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            cyc(1);
            lat++;
            if (!io.coin_n[0]) found = 1'b1;
        end
        check_eq("abort_pulse_seen", 32'(found), 32'd1);
        cyc(2);
        reset = 1'b1;
        #1;
        check_eq("abort_coin_hi", 32'(io.coin_n[0]), 32'd1);
        io.joy0_i[4] = 1'b0;
        cyc(3);
        reset = 1'b0;
        watch_coin(0, 60, pulses, width, ticks);
        check_eq("abort_no_pulse", 32'(pulses + width), 32'd0);
        io.joy0_i[4] = 1'b1;
        watch_coin(0, 40, pulses, width, ticks);
        check_eq("post_abort_pulse", 32'(pulses), 32'd1);
        io.joy0_i[4] = 1'b0;
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
